// File: rtl/pipeline_stage_tracker_pkg.sv
// Shared types for the RV32 pipeline stage tracker: instruction/register types,
// load opcode, and the instruction+write-enable pair carried by each stage.
package pipeline_stage_tracker_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  typedef struct packed {
    word_t instr;
    logic  wen;
  } pipe_slot_t;

endpackage

// File: rtl/pipeline_stage_tracker_pipe_slot.sv
// One pipeline stage slot: async-reset register of an instruction/write-enable
// pair that can hold (en=0) or load a NOP bubble instead of its input.
module pipe_slot
  import pipeline_stage_tracker_pkg::*;
#(
  parameter word_t NOP_INSTR = 32'h0000_0013
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       bubble,
  input  pipe_slot_t d,
  output pipe_slot_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '{instr: NOP_INSTR, wen: 1'b0};
    end else if (en) begin
      if (bubble) q <= '{instr: NOP_INSTR, wen: 1'b0};
      else        q <= d;
    end
  end

endmodule

// File: rtl/pipeline_stage_tracker.sv
// Tracks the EXE/MEM/WB instruction and write-enable for the forwarding unit,
// inserts load-use bubbles, applies branch flushes and memory-wait freezes.
module pipeline_stage_tracker
  import pipeline_stage_tracker_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [31:0]      instr_id,
  input  logic             wen_id,
  input  logic             uses_rs1_id,
  input  logic             uses_rs2_id,
  input  logic             flush_ex,
  input  logic             mem_wait,
  output logic [31:0]      imemload_exe,
  output logic [31:0]      imemload_mem,
  output logic [31:0]      imemload_wb,
  output logic             WEN_exe,
  output logic             WEN_mem,
  output logic             WEN_wb,
  output logic             stall_id,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  pipe_slot_t slot_id, slot_exe, slot_mem, slot_wb;
  regbits_t   rd_exe, rs1_id, rs2_id;
  logic       load_use, advance, bubble_exe;

  assign rd_exe  = imemload_exe[11:7];
  assign rs1_id  = instr_id[19:15];
  assign rs2_id  = instr_id[24:20];
  assign slot_id = '{instr: instr_id, wen: wen_id};

  // x0 as destination never creates a dependency, even with WEN set
  assign load_use = (imemload_exe[6:0] == OPC_LOAD) && WEN_exe && (rd_exe != 5'd0)
                    && ((uses_rs1_id && (rs1_id == rd_exe)) ||
                        (uses_rs2_id && (rs2_id == rd_exe)));

  assign advance    = ~mem_wait;
  assign bubble_exe = flush_ex | load_use;
  assign stall_id   = mem_wait | (load_use & ~flush_ex);

  pipe_slot #(.NOP_INSTR(NOP_INSTR)) u_exe (
    .clk(CLK), .rst_n(nRST), .en(advance), .bubble(bubble_exe), .d(slot_id),  .q(slot_exe)
  );
  pipe_slot #(.NOP_INSTR(NOP_INSTR)) u_mem (
    .clk(CLK), .rst_n(nRST), .en(advance), .bubble(1'b0),       .d(slot_exe), .q(slot_mem)
  );
  pipe_slot #(.NOP_INSTR(NOP_INSTR)) u_wb (
    .clk(CLK), .rst_n(nRST), .en(advance), .bubble(1'b0),       .d(slot_mem), .q(slot_wb)
  );

  assign imemload_exe = slot_exe.instr;
  assign imemload_mem = slot_mem.instr;
  assign imemload_wb  = slot_wb.instr;
  assign WEN_exe      = slot_exe.wen;
  assign WEN_mem      = slot_mem.wen;
  assign WEN_wb       = slot_wb.wen;

  // Flush wins over load-use, so a killed consumer is not counted as a bubble
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (advance) begin
      if (flush_ex)      flush_cnt  <= sat_inc(flush_cnt);
      else if (load_use) bubble_cnt <= sat_inc(bubble_cnt);
    end
  end

endmodule
